// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants for the multi-channel tick generator.
// Holds default counter width, the reset divisor and common rate divisors
// for a 31.5 MHz system clock.
package tick_gen_pkg;

    // Default counter/divisor width and reset divisor (1 Hz at 31.5 MHz)
    localparam int CNT_W_DEF       = 25;
    localparam int DEFAULT_DIV_DEF = 31_500_000;

    // Common divisors at 31.5 MHz
    localparam int DIV_1HZ  = 31_500_000;
    localparam int DIV_60HZ = 525_000;
    localparam int DIV_4HZ  = 7_875_000;

    // Width of a channel index; a single channel still gets a 1-bit select
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one channel of the tick generator.
// Holds the divisor register, the phase counter and the registered tick /
// square outputs. When TICK_GEN_ONESHOT_EN is defined, a per-channel mode
// bit lets the channel stop after its first tick and raise o_done.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_en,
    input  logic             i_clr,
`ifdef TICK_GEN_ONESHOT_EN
    input  logic             i_oneshot,
    output logic             o_done,
`endif
    output logic             o_tick,
    output logic             o_square
);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_square;
    logic [CNT_W-1:0] w_last;
    logic             w_term;
    logic             w_run;

`ifdef TICK_GEN_ONESHOT_EN
    logic r_mode;
    logic r_fired;
    logic r_done;
`endif

    // Terminal count is Deff-1 with Deff = max(div,1), so div 0 and 1 both tick every cycle
    always_comb begin
        w_last = '0;
        if (r_div > CNT_W'(1)) begin
            w_last = r_div - CNT_W'(1);
        end
        w_term = (r_cnt == w_last);
`ifdef TICK_GEN_ONESHOT_EN
        // A fired one-shot channel is parked: counter frozen at 0, no ticks
        w_run  = i_en && !(r_mode && r_fired);
`else
        w_run  = i_en;
`endif
    end

    // Divisor register: a write lands even when a clear happens the same cycle
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_div <= RST_DIV;
        end else if (i_we) begin
            r_div <= i_div;
        end
    end

    // Phase counter, tick strobe and square toggle; clear beats write beats terminal count
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_square <= 1'b0;
        end else if (i_clr) begin
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_square <= 1'b0;
        end else if (i_we) begin
            // Restarting the phase on every write means a lowered divisor can never
            // leave the counter above its new terminal value
            r_cnt    <= '0;
            r_tick   <= 1'b0;
        end else if (w_run) begin
            if (w_term) begin
                r_cnt    <= '0;
                r_tick   <= 1'b1;
                r_square <= ~r_square;
            end else begin
                r_cnt    <= r_cnt + CNT_W'(1);
                r_tick   <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

`ifdef TICK_GEN_ONESHOT_EN
    // One-shot bookkeeping: write or clear re-arms; done trails the single tick by one cycle
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_mode  <= 1'b0;
            r_fired <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (i_we) begin
                r_mode <= i_oneshot;
            end
            if (i_clr || i_we) begin
                r_fired <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                r_done <= r_fired;
                if (w_run && w_term && r_mode) begin
                    r_fired <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
`endif

    assign o_tick   = r_tick;
    assign o_square = r_square;

endmodule

// File: rtl/tick_gen.sv
// tick_gen: NUM_CH independent programmable tick generators.
// Each channel emits a one-cycle clock-enable strobe every max(div,1) enabled
// cycles plus a 50%-duty square that toggles on each tick. Divisors are
// written at run time through cfg_we/cfg_ch/cfg_div.
// Optional feature macro: TICK_GEN_ONESHOT_EN adds cfg_oneshot and done.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  CNT_W       = CNT_W_DEF,
    parameter int  DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W        = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_clr,
`ifdef TICK_GEN_ONESHOT_EN
    input  logic              cfg_oneshot,
    output logic [NUM_CH-1:0] done,
`endif
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] square
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    logic [NUM_CH-1:0] w_we;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Indices at or beyond NUM_CH match no channel, so such writes are dropped
            assign w_we[gi] = cfg_we && (cfg_ch == CH_W'(gi));

            tick_gen_ch #(
                .CNT_W   (CNT_W),
                .RST_DIV (RST_DIV)
            ) u_ch (
                .clk       (clk),
                .resetN    (resetN),
                .i_we      (w_we[gi]),
                .i_div     (cfg_div),
                .i_en      (ch_en[gi]),
                .i_clr     (sync_clr),
`ifdef TICK_GEN_ONESHOT_EN
                .i_oneshot (cfg_oneshot),
                .o_done    (done[gi]),
`endif
                .o_tick    (tick[gi]),
                .o_square  (square[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed scenarios plus randomized traffic for tick_gen,
// checked every cycle against an arithmetic reference model.
// Build with TICK_GEN_ONESHOT_EN defined to exercise the one-shot mode too.
module tb_tick_gen;

    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int DDIV = 9;

    logic           clk = 1'b0;
    logic           resetN;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic [NCH-1:0] ch_en;
    logic           sync_clr;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] square;
`ifdef TICK_GEN_ONESHOT_EN
    logic           cfg_oneshot;
    logic [NCH-1:0] done;
`endif

    tick_gen #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .ch_en       (ch_en),
        .sync_clr    (sync_clr),
`ifdef TICK_GEN_ONESHOT_EN
        .cfg_oneshot (cfg_oneshot),
        .done        (done),
`endif
        .tick        (tick),
        .square      (square)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: enabled edges since the last restart, and the tick
    // count parity; a tick lands whenever that edge count is a multiple of Deff.
    int m_div   [NCH];
    int m_since [NCH];
    bit m_tick  [NCH];
    bit m_sq    [NCH];
    bit m_mode  [NCH];
    bit m_fired [NCH];
`ifdef TICK_GEN_ONESHOT_EN
    bit m_done  [NCH];
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = DDIV; m_since[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
            m_mode[i] = 0; m_fired[i] = 0;
`ifdef TICK_GEN_ONESHOT_EN
            m_done[i] = 0;
`endif
        end
    endtask

    // Advance the model by one rising edge using the inputs present at that edge
    task automatic model_edge();
        bit os;
        int deff;
`ifdef TICK_GEN_ONESHOT_EN
        os = cfg_oneshot;
`else
        os = 1'b0;
`endif
        for (int i = 0; i < NCH; i++) begin
            bit we;
            we = cfg_we && (int'(cfg_ch) == i);
            if (we) begin
                m_div[i] = int'(cfg_div);
                m_mode[i] = os;
            end
            if (sync_clr || we) begin
                m_since[i] = 0; m_tick[i] = 0; m_fired[i] = 0;
                if (sync_clr) m_sq[i] = 0;
`ifdef TICK_GEN_ONESHOT_EN
                m_done[i] = 0;
`endif
            end else begin
`ifdef TICK_GEN_ONESHOT_EN
                m_done[i] = m_fired[i];
`endif
                m_tick[i] = 0;
                if (ch_en[i] && !(m_mode[i] && m_fired[i])) begin
                    deff = (m_div[i] < 1) ? 1 : m_div[i];
                    m_since[i]++;
                    if (m_since[i] % deff == 0) begin
                        m_tick[i] = 1;
                        m_sq[i] = !m_sq[i];
                        if (m_mode[i]) m_fired[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        logic [NCH-1:0] et, es;
        for (int i = 0; i < NCH; i++) begin
            et[i] = m_tick[i];
            es[i] = m_sq[i];
        end
        chk("tick", 32'(tick), 32'(et));
        chk("square", 32'(square), 32'(es));
`ifdef TICK_GEN_ONESHOT_EN
        for (int i = 0; i < NCH; i++) es[i] = m_done[i];
        chk("done", 32'(done), 32'(es));
`endif
    endtask

    // One clock: edge, model update, sample 1 ns later, then drop one-cycle strobes
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        cfg_we   = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(input int ch, input int d, input bit os);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = CW'(d);
`ifdef TICK_GEN_ONESHOT_EN
        cfg_oneshot = os;
`else
        if (os) $display("note: one-shot request ignored in periodic build");
`endif
        step();
`ifdef TICK_GEN_ONESHOT_EN
        cfg_oneshot = 1'b0;
`endif
    endtask

    initial begin
        resetN = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        ch_en = '0; sync_clr = 1'b0;
`ifdef TICK_GEN_ONESHOT_EN
        cfg_oneshot = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        resetN = 1'b1;

        // ch0 at div 5: tick every 5, square period 10, others silent
        ch_en = 3'b001;
        wr(0, 5, 0);
        cyc(25);

        // ch1 at div 0 then div 1: tick every cycle
        ch_en = 3'b011;
        wr(1, 0, 0);
        cyc(6);
        wr(1, 1, 0);
        cyc(6);

        // ch2 at div 4 with a 3-cycle enable gap mid-count
        ch_en = 3'b111;
        wr(2, 4, 0);
        cyc(6);
        ch_en[2] = 1'b0;
        cyc(3);
        ch_en[2] = 1'b1;
        cyc(10);

        // Write landing on the terminal-count cycle suppresses that tick
        wr(2, 4, 0);
        cyc(3);
        wr(2, 6, 0);
        cyc(14);

        // Out-of-range channel index changes nothing
        wr(3, 2, 0);
        cyc(10);

        // sync_clr with channels at 3/5/7, then clear coinciding with a write
        wr(0, 3, 0);
        wr(1, 5, 0);
        wr(2, 7, 0);
        cyc(11);
        sync_clr = 1'b1;
        step();
        cyc(20);
        sync_clr = 1'b1;
        wr(1, 2, 0);
        cyc(10);

        // Asynchronous reset mid-cycle: outputs drop before the next edge
        cyc(2);
        #3;
        resetN = 1'b0;
        #1;
        chk("rst_async_tick", 32'(tick), 32'd0);
        chk("rst_async_square", 32'(square), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        compare();
        resetN = 1'b1;
        cyc(25);

`ifdef TICK_GEN_ONESHOT_EN
        // One-shot: a single tick, done a cycle later, re-armed by rewrite
        ch_en = 3'b001;
        wr(0, 6, 1);
        cyc(12);
        wr(0, 6, 1);
        cyc(12);
        sync_clr = 1'b1;
        step();
        cyc(10);
        wr(0, 3, 0);
        cyc(8);
`endif

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            ch_en    = 3'($urandom);
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_ch   = 2'($urandom_range(0, 3));
            cfg_div  = CW'($urandom_range(0, 7));
            sync_clr = ($urandom_range(0, 39) == 0);
`ifdef TICK_GEN_ONESHOT_EN
            cfg_oneshot = ($urandom_range(0, 3) == 0);
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
